// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Arbitrates two requesters onto one shared, external combinational ALU.
// A request seen in IDLE is granted, and the winner's opcode and operands are
// latched. In EXEC the latched values drive the ALU, and the ALU outputs are
// registered at the end of that cycle. In RESP the winner's Done is held until
// that requester acknowledges.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   Req0/1, Op0/1        per-requester request and 3-bit opcode
//   A0/B0, A1/B1         per-requester operands (WIDTH bits)
//   Ack0/1               requester has consumed its result
//   Gnt0/1               one-cycle pulse: operands of that requester latched
//   Done0/1              result valid for that requester, held until acked
//   Result, ZeroOut      registered ALU result and Zero flag
//   IllegalOp            registered flag: latched opcode was 011 or 111
//   SrcA, SrcB           operands to the shared ALU (always the latched values)
//   ALUControl           opcode to the shared ALU (always the latched value)
//   ALUResult, Zero      combinational return from the shared ALU
//
// Configuration
//   ALU_ARB_RR_EN        defined: round-robin between the two requesters on
//                        ties. Undefined: requester 0 always wins ties.
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [2:0]       Op0,
    input  logic [2:0]       Op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic             Ack0,
    input  logic             Ack1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroOut,
    output logic             IllegalOp,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sel_q;      // requester that owns the in-flight operation
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             any_req;
    logic             win;        // requester chosen if a grant happens now
    logic             acked;

    assign any_req = Req0 | Req1;
    assign acked   = sel_q ? Ack1 : Ack0;

`ifdef ALU_ARB_RR_EN
    logic last_q;  // most recently granted requester

    // On a tie the requester not granted last wins; otherwise the lone requester.
    always_comb begin
        win = Req1;
        if (Req0 && Req1) begin
            win = ~last_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_q <= win;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it asks.
    assign win = ~Req0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-requester handshake outputs
    always_comb begin
        state_nxt = state;
        Gnt0      = 1'b0;
        Gnt1      = 1'b0;
        Done0     = 1'b0;
        Done1     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                Gnt0      = ~sel_q;
                Gnt1      = sel_q;
                state_nxt = RESP;
            end
            RESP: begin
                Done0 = ~sel_q;
                Done1 = sel_q;
                if (acked) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            Result    <= '0;
            ZeroOut   <= 1'b0;
            IllegalOp <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                sel_q <= win;
                if (win) begin
                    op_q <= Op1;
                    a_q  <= A1;
                    b_q  <= B1;
                end else begin
                    op_q <= Op0;
                    a_q  <= A0;
                    b_q  <= B0;
                end
            end
            if (state == EXEC) begin
                Result    <= ALUResult;
                ZeroOut   <= Zero;
                // 011 and 111 are the only unassigned encodings
                IllegalOp <= (op_q[1:0] == 2'b11);
            end
        end
    end

    assign SrcA       = a_q;
    assign SrcB       = b_q;
    assign ALUControl = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         Req0, Req1, Ack0, Ack1;
    logic [2:0]   Op0, Op1;
    logic [W-1:0] A0, B0, A1, B1;
    logic         Gnt0, Gnt1, Done0, Done1, ZeroOut, IllegalOp, Zero;
    logic [W-1:0] Result, SrcA, SrcB, ALUResult;
    logic [2:0]   ALUControl;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: what each opcode means
    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a - b;
            3'b101:  return a * b;
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // The shared ALU lives in the bench
    assign ALUResult = alu_ref(ALUControl, SrcA, SrcB);
    assign Zero      = (ALUResult == '0);

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Ack0(Ack0), .Ack1(Ack1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
        .Result(Result), .ZeroOut(ZeroOut), .IllegalOp(IllegalOp),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           mdl_last = 1;   // most recently granted requester
    int           exp_w;
    logic [2:0]   exp_op;
    logic [W-1:0] exp_a, exp_b, exp_res;
    logic         exp_zero, exp_ill;

    // Observations captured by the transaction driver
    logic         obs_g0, obs_g1, obs_dn1, obs_d0, obs_d1, obs_zero, obs_ill;
    logic         obs_hold_ok, obs_done_after, obs_gnt_after;
    logic [W-1:0] obs_res, obs_srca, obs_srcb, obs_res_after;
    logic [2:0]   obs_ctl;

    function automatic int pick_winner(input logic r0, input logic r1);
`ifdef ALU_ARB_RR_EN
        if (r0 && r1) return (mdl_last == 1) ? 0 : 1;
`endif
        return r0 ? 0 : 1;
    endfunction

    // Drives one full request/grant/ack transaction. Called at a negedge in an
    // IDLE cycle; returns at the negedge of the IDLE cycle following the ack.
    task automatic txn(input logic r0, input logic r1,
                       input logic [2:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [2:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic [1:0] req_after, input int ackdly, input bit spurious);
        Req0 = r0; Req1 = r1; Op0 = o0; A0 = a0; B0 = b0; Op1 = o1; A1 = a1; B1 = b1;
        Ack0 = 1'b0; Ack1 = 1'b0;
        exp_w    = pick_winner(r0, r1);
        mdl_last = exp_w;
        exp_op   = (exp_w == 1) ? o1 : o0;
        exp_a    = (exp_w == 1) ? a1 : a0;
        exp_b    = (exp_w == 1) ? b1 : b0;
        exp_res  = alu_ref(exp_op, exp_a, exp_b);
        exp_zero = (exp_res == '0);
        exp_ill  = (exp_op == 3'b011) || (exp_op == 3'b111);
        @(negedge clk);
        obs_g0 = Gnt0; obs_g1 = Gnt1; obs_dn1 = Done0 | Done1;
        // Disturb everything the in-flight operation must no longer depend on
        Req0 = req_after[0]; Req1 = req_after[1];
        Op0 = 3'($urandom); Op1 = 3'($urandom);
        A0 = $urandom; B0 = $urandom; A1 = $urandom; B1 = $urandom;
        @(negedge clk);
        obs_d0 = Done0; obs_d1 = Done1; obs_res = Result; obs_zero = ZeroOut; obs_ill = IllegalOp;
        obs_srca = SrcA; obs_srcb = SrcB; obs_ctl = ALUControl;
        obs_hold_ok = 1'b1;
        for (int i = 0; i < ackdly; i++) begin
            if (spurious) begin
                if (exp_w == 1) Ack0 = 1'b1; else Ack1 = 1'b1;
            end
            @(negedge clk);
            if (Done0 !== (exp_w == 0) || Done1 !== (exp_w == 1) || Gnt0 !== 1'b0 || Gnt1 !== 1'b0 || Result !== exp_res)
                obs_hold_ok = 1'b0;
        end
        Ack0 = (exp_w == 0); Ack1 = (exp_w == 1);
        @(negedge clk);
        obs_done_after = Done0 | Done1; obs_gnt_after = Gnt0 | Gnt1; obs_res_after = Result;
        Ack0 = 1'b0; Ack1 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Ack0 = 1'b0; Ack1 = 1'b0;
        Op0 = '0; Op1 = '0; A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        repeat (3) @(negedge clk);
        checks++; if ({Gnt0, Gnt1, Done0, Done1} !== 4'b0000) begin failures++; $display("FAIL reset_handshake: got %b expected 0000", {Gnt0, Gnt1, Done0, Done1}); end
        checks++; if ({ZeroOut, IllegalOp} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {ZeroOut, IllegalOp}); end
        checks++; if (Result !== '0) begin failures++; $display("FAIL reset_result: got %0h expected 0", Result); end
        checks++; if ({SrcA, SrcB, ALUControl} !== '0) begin failures++; $display("FAIL reset_alu_drive: got %0h %0h %0h expected 0", SrcA, SrcB, ALUControl); end
        rst = 1'b1;
        mdl_last = 1;
        @(negedge clk);
        checks++; if ({Gnt0, Gnt1, Done0, Done1} !== 4'b0000) begin failures++; $display("FAIL idle_no_req: got %b expected 0000", {Gnt0, Gnt1, Done0, Done1}); end
    endtask

    task automatic test_add;
        txn(1'b1, 1'b0, 3'b010, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 2'b00, 2, 1'b0);
        checks++; if ({obs_g1, obs_g0, obs_dn1} !== 3'b010) begin failures++; $display("FAIL add_gnt: got g1g0dn=%b expected 010", {obs_g1, obs_g0, obs_dn1}); end
        checks++; if ({obs_d1, obs_d0} !== 2'b01) begin failures++; $display("FAIL add_done: got %b expected 01", {obs_d1, obs_d0}); end
        checks++; if (obs_res !== 32'd12) begin failures++; $display("FAIL add_result: got %0d expected 12", obs_res); end
        checks++; if ({obs_zero, obs_ill} !== 2'b00) begin failures++; $display("FAIL add_flags: got %b expected 00", {obs_zero, obs_ill}); end
        checks++; if (obs_hold_ok !== 1'b1) begin failures++; $display("FAIL add_hold: got %b expected 1", obs_hold_ok); end
        checks++; if (obs_done_after !== 1'b0) begin failures++; $display("FAIL add_ack: got %b expected 0", obs_done_after); end
        checks++; if (obs_res_after !== 32'd12) begin failures++; $display("FAIL add_result_held: got %0d expected 12", obs_res_after); end
    endtask

    task automatic test_sub_zero;
        txn(1'b0, 1'b1, 3'b000, 32'd1, 32'd2, 3'b100, 32'd9, 32'd9, 2'b00, 3, 1'b1);
        checks++; if ({obs_g1, obs_g0} !== 2'b10) begin failures++; $display("FAIL sub_gnt: got %b expected 10", {obs_g1, obs_g0}); end
        checks++; if ({obs_d1, obs_d0} !== 2'b10) begin failures++; $display("FAIL sub_done: got %b expected 10", {obs_d1, obs_d0}); end
        checks++; if (obs_res !== '0 || obs_zero !== 1'b1) begin failures++; $display("FAIL sub_result: got %0d z=%b expected 0 z=1", obs_res, obs_zero); end
        checks++; if (obs_hold_ok !== 1'b1) begin failures++; $display("FAIL sub_hold_done0_low: got %b expected 1", obs_hold_ok); end
        checks++; if (obs_done_after !== 1'b0) begin failures++; $display("FAIL sub_ack: got %b expected 0", obs_done_after); end
    endtask

    task automatic test_tie;
        int exp_order [3];
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, 3'b101, $urandom, $urandom, (i == 2) ? 2'b00 : 2'b11, 1, 1'b0);
            checks++; if ({obs_g1, obs_g0} !== ((exp_order[i] == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_order[%0d]: got g1g0=%b expected requester %0d", i, {obs_g1, obs_g0}, exp_order[i]); end
            checks++; if (obs_res !== exp_res) begin failures++; $display("FAIL tie_result[%0d]: got %0h expected %0h", i, obs_res, exp_res); end
        end
    endtask

    task automatic test_illegal;
        txn(1'b1, 1'b0, 3'b011, $urandom | 32'h1, $urandom, 3'b010, 32'd1, 32'd1, 2'b00, 1, 1'b0);
        checks++; if (obs_ill !== 1'b1) begin failures++; $display("FAIL illegal_flag: got %b expected 1", obs_ill); end
        checks++; if (obs_res !== '0) begin failures++; $display("FAIL illegal_result: got %0h expected 0", obs_res); end
        checks++; if (obs_ctl !== 3'b011) begin failures++; $display("FAIL illegal_passthru: got %b expected 011", obs_ctl); end
        checks++; if ({obs_g0, obs_d0, obs_done_after} !== 3'b110) begin failures++; $display("FAIL illegal_flow: got %b expected 110", {obs_g0, obs_d0, obs_done_after}); end
    endtask

    task automatic test_ack_hold;
        txn(1'b1, 1'b0, 3'b001, 32'hF0, 32'h0F, 3'b010, 32'd3, 32'd4, 2'b10, 10, 1'b1);
        checks++; if (obs_hold_ok !== 1'b1) begin failures++; $display("FAIL hold_done0_no_gnt1: got %b expected 1", obs_hold_ok); end
        checks++; if ({obs_done_after, obs_gnt_after} !== 2'b00) begin failures++; $display("FAIL hold_idle_after_ack: got %b expected 00", {obs_done_after, obs_gnt_after}); end
        txn(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 3'b010, 32'd3, 32'd4, 2'b00, 0, 1'b0);
        checks++; if ({obs_g1, obs_g0} !== 2'b10) begin failures++; $display("FAIL hold_gnt1_next: got %b expected 10", {obs_g1, obs_g0}); end
        checks++; if (obs_res !== 32'd7) begin failures++; $display("FAIL hold_result1: got %0d expected 7", obs_res); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [1:0]   r;
            logic [W-1:0] ra0, ra1;
            int           gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                Req0 = 1'b0; Req1 = 1'b0; Ack0 = 1'($urandom); Ack1 = 1'($urandom);
                @(negedge clk);
            end
            r   = 2'($urandom_range(1, 3));
            ra0 = $urandom; ra1 = $urandom;
            txn(r[0], r[1], 3'($urandom), ra0, ($urandom_range(0, 3) == 0) ? ra0 : $urandom,
                3'($urandom), ra1, ($urandom_range(0, 3) == 0) ? ra1 : $urandom,
                2'($urandom), $urandom_range(0, 4), 1'($urandom));
            checks++; if ({obs_g1, obs_g0, obs_dn1} !== {exp_w == 1, exp_w == 0, 1'b0}) begin failures++; $display("FAIL rnd_gnt[%0d]: got g1g0dn=%b expected winner %0d", n, {obs_g1, obs_g0, obs_dn1}, exp_w); end
            checks++; if ({obs_d1, obs_d0} !== {exp_w == 1, exp_w == 0}) begin failures++; $display("FAIL rnd_done[%0d]: got %b expected winner %0d", n, {obs_d1, obs_d0}, exp_w); end
            checks++; if (obs_res !== exp_res) begin failures++; $display("FAIL rnd_result[%0d]: got %0h expected %0h", n, obs_res, exp_res); end
            checks++; if ({obs_zero, obs_ill} !== {exp_zero, exp_ill}) begin failures++; $display("FAIL rnd_flags[%0d]: got %b expected %b", n, {obs_zero, obs_ill}, {exp_zero, exp_ill}); end
            checks++; if ({obs_srca, obs_srcb, obs_ctl} !== {exp_a, exp_b, exp_op}) begin failures++; $display("FAIL rnd_alu_drive[%0d]: got %0h %0h %0h expected %0h %0h %0h", n, obs_srca, obs_srcb, obs_ctl, exp_a, exp_b, exp_op); end
            checks++; if (obs_hold_ok !== 1'b1) begin failures++; $display("FAIL rnd_hold[%0d]: got %b expected 1", n, obs_hold_ok); end
            checks++; if ({obs_done_after, obs_gnt_after} !== 2'b00) begin failures++; $display("FAIL rnd_ack[%0d]: got %b expected 00", n, {obs_done_after, obs_gnt_after}); end
            checks++; if (obs_res_after !== exp_res) begin failures++; $display("FAIL rnd_result_held[%0d]: got %0h expected %0h", n, obs_res_after, exp_res); end
        end
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic test_reset_mid;
        // Put something nonzero in the result register first
        txn(1'b1, 1'b0, 3'b001, 32'hA5, 32'h5A00, 3'b000, 32'd0, 32'd0, 2'b00, 0, 1'b0);
        Req0 = 1'b1; Op0 = 3'b010; A0 = 32'd100; B0 = 32'd23;
        @(negedge clk);
        checks++; if (Gnt0 !== 1'b1) begin failures++; $display("FAIL rstmid_in_exec: got %b expected 1", Gnt0); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({Gnt0, Gnt1, Done0, Done1, ZeroOut, IllegalOp} !== 6'b0) begin failures++; $display("FAIL rstmid_ctrl: got %b expected 000000", {Gnt0, Gnt1, Done0, Done1, ZeroOut, IllegalOp}); end
        checks++; if ({Result, SrcA, SrcB, ALUControl} !== '0) begin failures++; $display("FAIL rstmid_data: got %0h %0h %0h %0h expected 0", Result, SrcA, SrcB, ALUControl); end
        Req0 = 1'b0;
        @(negedge clk);
        checks++; if ({Done0, Done1} !== 2'b00) begin failures++; $display("FAIL rstmid_no_done: got %b expected 00", {Done0, Done1}); end
        rst = 1'b1;
        mdl_last = 1;
        txn(1'b1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'd1, 32'd2, 2'b00, 1, 1'b0);
        checks++; if ({obs_g1, obs_g0} !== 2'b01) begin failures++; $display("FAIL rstmid_fresh_gnt: got %b expected 01", {obs_g1, obs_g0}); end
        checks++; if (obs_res !== 32'd1 || obs_d0 !== 1'b1) begin failures++; $display("FAIL rstmid_fresh_result: got %0h d0=%b expected 1 d0=1", obs_res, obs_d0); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_zero;
        test_tie;
        test_illegal;
        test_ack_hold;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
